univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits; the legal range is 2..64.
REQ-002 Parameter RESET_VAL, default 0, value loaded into q on reset.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port reset, input, 1, reset; it is synchronous and active-high.
REQ-005 Port en, input, 1, operation enable; when it is 0 the block holds.
REQ-006 Port mode, input, 3, operation select (see REQ-011).
REQ-007 Port d, input, WIDTH, parallel load data.
REQ-008 Port sin, input, 1, serial input bit for shift operations.
REQ-009 Port q, output, WIDTH, registered state; qn, output, WIDTH, bitwise inverse of q (combinational).
REQ-010 Port sout, output, 1, registered bit shifted or rotated out; carry, output, 1, registered wrap pulse; zero, output, 1, combinational flag that is high when q equals 0.

Function
REQ-011 The mode encoding SHALL be as follows:
- 000 HOLD
- 001 LOAD: q<=d
- 010 SHL: q<={q[W-2:0],sin}
- 011 SHR: q<={sin,q[W-1:1]}
- 100 ROL: q<={q[W-2:0],q[W-1]}
- 101 ROR: q<={q[0],q[W-1:1]}
- 110 INC: q<=q+1 mod 2^W
- 111 DEC: q<=q-1 mod 2^W
REQ-012 All updates of q, sout and carry SHALL occur on the rising clk edge, with single-cycle latency from the sampled inputs to the q update.
REQ-013 When en=0, q and sout SHALL hold, and carry SHALL be 0 on the following cycle.
REQ-014 sout SHALL capture the departing bit: q[W-1] for SHL and ROL, q[0] for SHR and ROR; for all other modes it SHALL hold its previous value.
REQ-015 carry SHALL be 1 for exactly one cycle after an INC from all-ones (wrap to 0) or a DEC from 0 (wrap to all-ones); otherwise it SHALL be 0.
REQ-016 qn SHALL always equal ~q, and zero SHALL always equal (q==0), both with no added latency.
REQ-017 The state machine SHALL consist of q only; there are no hidden states.
REQ-018 The mode is sampled every enabled cycle, so back-to-back mode changes SHALL take effect on consecutive cycles.
REQ-019 All arithmetic SHALL be unsigned at WIDTH bits; the overflow bit SHALL feed carry and SHALL NOT be stored elsewhere.

Reset
REQ-020 On a clk edge with reset=1, q SHALL become RESET_VAL, sout SHALL become 0 and carry SHALL become 0, regardless of en, mode and d.
REQ-021 reset SHALL have priority over every mode; an operation in progress is discarded and no partial update is visible.
REQ-022 Between power-up and the first reset edge, the outputs are undefined; the bench SHALL apply reset before any checks.

Structure
REQ-023 The mode encodings (8 named constants, 3 bits each) SHALL live in the shared package univ_reg_pkg.
REQ-024 No sub-module is required; the block SHALL be a single module with one clocked process and combinational assigns for qn and zero.
REQ-025 The RTL SHALL be synthesizable for any legal WIDTH without edits.

Verification (WIDTH=4, RESET_VAL=0)
REQ-026 Reset: reset=1 for 1 edge with mode=LOAD, d=1010 -> q=0000, qn=1111, sout=0, carry=0, zero=1.
REQ-027 Load/hold: LOAD d=1011, then en=0 for 3 cycles with d=0110 -> q stays 1011 and carry=0 throughout.
REQ-028 Shift: starting from q=1011, apply SHL sin=0 -> q=0110, sout=1; then SHR sin=1 -> q=1011, sout=0.
REQ-029 Rotate: starting from q=1000, apply ROL 4 times -> q=0001, 0010, 0100, 1000, and sout =1, 0, 0, 0.
REQ-030 Wrap: starting from q=1110, apply INC x2 -> q=1111 with carry=0, then q=0000 with carry=1 and zero=1; then DEC -> q=1111 with carry=1; then HOLD -> carry=0.
REQ-031 Reset mid-op: assert reset during an INC at q=1111 -> q=0000 and carry=0 (the wrap pulse is suppressed).

Source files
------------

// File: rtl/univ_reg_pkg.sv
// Shared definitions for the universal shift register: the 3-bit mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package univ_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_shift_reg.sv
// Universal register: hold/load/shift/rotate/increment/decrement selected by mode.
// Latency: one clk from sampled inputs to q/sout/carry; qn and zero are combinational from q.
// Backpressure: none; en=0 holds q and sout and clears carry.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset (to RESET_VAL)
//   en, mode       operation enable and 3-bit operation select
//   d, sin         parallel load data and serial shift-in bit
//   q, qn          registered state and its bitwise inverse
//   sout           last bit shifted/rotated out (holds for other modes)
//   carry          one-cycle pulse after an INC/DEC wraps
//   zero           high while q == 0
module univ_shift_reg
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              sout,
  output logic              carry,
  output logic              zero
);

  // One extra bit on the arithmetic paths: bit WIDTH is the carry-out of
  // the increment and the borrow-out of the decrement. It only ever feeds
  // the carry flag; q keeps the low WIDTH bits (wrap mod 2^WIDTH).
  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  assign inc_sum  = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec_diff = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RESET_VAL;
      sout  <= 1'b0;
      carry <= 1'b0;
    end else if (!en) begin
      // q and sout keep their values; carry is strictly a one-cycle pulse
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: q <= d;
        MODE_SHL: begin
          q    <= {q[WIDTH-2:0], sin};
          sout <= q[WIDTH-1];
        end
        MODE_SHR: begin
          q    <= {sin, q[WIDTH-1:1]};
          sout <= q[0];
        end
        MODE_ROL: begin
          q    <= {q[WIDTH-2:0], q[WIDTH-1]};
          sout <= q[WIDTH-1];
        end
        MODE_ROR: begin
          q    <= {q[0], q[WIDTH-1:1]};
          sout <= q[0];
        end
        MODE_INC: begin
          q     <= inc_sum[WIDTH-1:0];
          carry <= inc_sum[WIDTH];
        end
        MODE_DEC: begin
          q     <= dec_diff[WIDTH-1:0];
          carry <= dec_diff[WIDTH];
        end
        default: ;
      endcase
    end
  end

  assign qn   = ~q;
  assign zero = (q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4, RESET_VAL=0).
// Stimulus is driven on the falling edge and the hand-computed expectation
// for the following rising edge is queued; a monitor pops and checks #1
// after every rising edge while the queue is non-empty.
module tb_univ_shift_reg;
  import univ_reg_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         sout;
  logic         carry;
  logic         zero;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .qn    (qn),
    .sout  (sout),
    .carry (carry),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         sout;
    logic         carry;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Drive one cycle of inputs and queue the expected post-edge state.
  task automatic apply(input string name, input logic r, input logic e,
                       input logic [2:0] m, input logic [W-1:0] dd,
                       input logic s, input logic [W-1:0] eq,
                       input logic es, input logic ec);
    exp_t x;
    @(negedge clk);
    reset = r;
    en    = e;
    mode  = m;
    d     = dd;
    sin   = s;
    x.name  = name;
    x.q     = eq;
    x.sout  = es;
    x.carry = ec;
    exp_q.push_back(x);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t x;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        bad = 1'b0;
        n_vec++;
        if (q !== x.q) begin
          $display("FAIL %s q: got %b expected %b", x.name, q, x.q);
          bad = 1'b1;
        end
        if (qn !== ~x.q) begin
          $display("FAIL %s qn: got %b expected %b", x.name, qn, ~x.q);
          bad = 1'b1;
        end
        if (sout !== x.sout) begin
          $display("FAIL %s sout: got %b expected %b", x.name, sout, x.sout);
          bad = 1'b1;
        end
        if (carry !== x.carry) begin
          $display("FAIL %s carry: got %b expected %b", x.name, carry, x.carry);
          bad = 1'b1;
        end
        if (zero !== (x.q == 4'b0000)) begin
          $display("FAIL %s zero: got %b expected %b", x.name, zero, (x.q == 4'b0000));
          bad = 1'b1;
        end
        if (bad) n_miss++;
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b0;
    en    = 1'b0;
    mode  = MODE_HOLD;
    d     = '0;
    sin   = 1'b0;

    //     name          rst  en  mode       d        sin   q        sout  carry
    apply("reset",       1'b1, 1'b1, MODE_LOAD, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0);
    apply("load",        1'b0, 1'b1, MODE_LOAD, 4'b1011, 1'b0, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      apply("hold_en0",  1'b0, 1'b0, MODE_LOAD, 4'b0110, 1'b0, 4'b1011, 1'b0, 1'b0);
    apply("shl",         1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0);
    apply("shr",         1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b1, 4'b1011, 1'b0, 1'b0);
    apply("load_1000",   1'b0, 1'b1, MODE_LOAD, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0);
    apply("rol1",        1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0);
    apply("rol2",        1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0);
    apply("rol3",        1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0);
    apply("rol4",        1'b0, 1'b1, MODE_ROL,  4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    apply("load_1110",   1'b0, 1'b1, MODE_LOAD, 4'b1110, 1'b0, 4'b1110, 1'b0, 1'b0);
    apply("inc1",        1'b0, 1'b1, MODE_INC,  4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    apply("inc_wrap",    1'b0, 1'b1, MODE_INC,  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    apply("dec_wrap",    1'b0, 1'b1, MODE_DEC,  4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1);
    apply("hold",        1'b0, 1'b1, MODE_HOLD, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
    apply("reset_inc",   1'b1, 1'b1, MODE_INC,  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    apply("load_1111",   1'b0, 1'b1, MODE_LOAD, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0);
    apply("inc_wrap2",   1'b0, 1'b1, MODE_INC,  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    apply("en0_clr_c",   1'b0, 1'b0, MODE_INC,  4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    apply("load_0001",   1'b0, 1'b1, MODE_LOAD, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
    apply("ror",         1'b0, 1'b1, MODE_ROR,  4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0);
    apply("dec",         1'b0, 1'b1, MODE_DEC,  4'b0000, 1'b0, 4'b0111, 1'b1, 1'b0);
    apply("shr_sin0",    1'b0, 1'b1, MODE_SHR,  4'b0000, 1'b0, 4'b0011, 1'b1, 1'b0);
    apply("reset_en0",   1'b1, 1'b0, MODE_SHL,  4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0);
    apply("dec_zero",    1'b0, 1'b1, MODE_DEC,  4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1);
    apply("ror_ones",    1'b0, 1'b1, MODE_ROR,  4'b0000, 1'b0, 4'b1111, 1'b1, 1'b0);
    apply("shl_sin1",    1'b0, 1'b1, MODE_SHL,  4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);

    @(negedge clk);
    en   = 1'b0;
    mode = MODE_HOLD;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      n_miss++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
